lc3b_data_mem_responder: RTL and testbench
==========================================

// Module: lc3b_data_mem_responder
// PURPOSE
//  Responder end of the LC-3b data-memory interface that the MEM pipeline stage drives.
//  Accepts one read or write request at a time from the MEM stage and serves it from an internal word array.
//  Answers after a programmable number of wait states, with a single-cycle mem_resp pulse.
//  Sits between the MEM stage and the data-memory side of the design.
// PARAMETERS
//  DEPTH_WORDS  256  number of 16-bit words stored; power of two, 2..32768
//  WAIT_STATES  3    extra cycles between request capture and mem_resp; 0..15
// PORTS
//  clk              in   1   single clock, all state updates on rising edge
//  rst_n            in   1   asynchronous active-low reset
//  mem_read         in   1   read request, held by initiator until mem_resp
//  mem_write        in   1   write request, held by initiator until mem_resp
//  mem_address      in   16  byte address; word index = mem_address[AW:1], AW=$clog2(DEPTH_WORDS)
//  mem_byte_enable  in   2   write byte lanes: [1]=bits 15:8, [0]=bits 7:0
//  mem_wdata        in   16  write data
//  mem_rdata        out  16  read data, valid in the mem_resp cycle of a read
//  mem_resp         out  1   one-cycle completion pulse
//  busy             out  1   high while a request is in service (WAIT or RESP)
//  proto_err        out  1   sticky: mem_read and mem_write both high while sampled in IDLE
// BEHAVIOUR
//  - Reset (async assert, sync release): state=IDLE, mem_resp=0, mem_rdata=16'h0000, busy=0, proto_err=0, counter=0.
//  - Reset does not clear the word array. Its contents are undefined after power-up.
//  - FSM states:
//    - IDLE: on (mem_read|mem_write), latch address, wdata, byte_enable and op; load counter=WAIT_STATES; go to WAIT.
//    - WAIT: if counter==0 go to RESP, else decrement. With WAIT_STATES=0, WAIT lasts exactly 1 cycle.
//    - RESP: mem_resp=1 for exactly this cycle; commit the write or drive the read data; go to IDLE.
//  - Latency: request first high in cycle t (IDLE) -> mem_resp high in cycle t+2+WAIT_STATES.
//  - Read:
//    - mem_rdata is registered and loaded with the array word on entry to RESP.
//    - It holds that value until the next read's RESP. Writes never change mem_rdata.
//    - mem_byte_enable is ignored for reads.
//  - Write:
//    - The array is updated at the RESP clock edge, only for lanes with mem_byte_enable=1.
//    - Byte enable 2'b00 completes normally with no change to the array.
//  - Abort: if both mem_read and mem_write are low during WAIT, return to IDLE with no mem_resp and no write committed.
//  - Read and write both high at capture: proto_err sets (sticky until reset) and the request is treated as a write.
//  - Back-to-back:
//    - The initiator drops its request in the cycle after mem_resp.
//    - A request still high in that cycle is captured as a new request (IDLE sees it).
//    - Minimum spacing between successive mem_resp pulses is 3+WAIT_STATES cycles.
//  - Address bits above AW wrap (aliasing). mem_address[0] is ignored.
//  - Inputs are only sampled in IDLE (capture) and WAIT (abort check). Changing them mid-WAIT otherwise has no effect.
//  - Reset mid-operation: an in-flight write is dropped, with no partial commit. mem_resp stays 0.
// TESTING
//  1. WAIT_STATES=3: write 16'hBEEF @16'h0010, BE=2'b11.
//     -> mem_resp in cycle t+5, exactly 1 cycle. Read @16'h0010 -> mem_rdata=16'hBEEF with mem_resp.
//  2. Byte lanes: write 16'h1234 @16'h0020 BE=11, then 16'hAB00 BE=10, then 16'h00CD BE=01.
//     -> Read @16'h0020 returns 16'hABCD.
//  3. Abort: start write 16'h5555 @16'h0030 (old value 16'h1111) and drop mem_write in WAIT.
//     -> No mem_resp. Read @16'h0030 returns 16'h1111.
//  4. Both mem_read and mem_write high, wdata 16'h7777 @16'h0040.
//     -> proto_err=1 and stays 1. Read @16'h0040 returns 16'h7777.
//  5. Aliasing, DEPTH_WORDS=256: write 16'hCAFE @16'h0002.
//     -> Read @16'h0202 returns 16'hCAFE. Read @16'h0003 returns 16'hCAFE.
//  6. Reset mid-WAIT of a write 16'h9999 @16'h0050 (old 16'h2222).
//     -> Outputs return to reset values. Read @16'h0050 after release returns 16'h2222.

Source files
------------

// File: rtl/lc3b_data_mem_responder.sv
// LC-3b data-memory responder: serves one MEM-stage read/write at a time
// from an internal word array, answering after WAIT_STATES wait cycles
// with a single-cycle mem_resp pulse.
module lc3b_data_mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [15:0] mem_address,
  input  logic [1:0]  mem_byte_enable,
  input  logic [15:0] mem_wdata,
  output logic [15:0] mem_rdata,
  output logic        mem_resp,
  output logic        busy,
  output logic        proto_err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t          state, nextState;
  logic [3:0]      waitCnt;
  logic [AW-1:0]   addrQ;
  logic [15:0]     wdataQ;
  logic [1:0]      beQ;
  logic            isWrite;
  logic [15:0]     memArray [DEPTH_WORDS];

  logic reqAny, capture, toResp;
  logic unusedAddr;

  assign reqAny  = mem_read | mem_write;
  assign capture = (state == IDLE) && reqAny;
  // WAIT leaves for RESP only if the initiator is still asking; a dropped
  // request in WAIT is an abort and takes priority over the expiry.
  assign toResp  = (state == WAIT) && reqAny && (waitCnt == 4'd0);

  // Address bits above the word index alias; bit 0 is a byte offset.
  assign unusedAddr = ^mem_address;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nextState;
  end

  // Next-state and status outputs
  always_comb begin
    nextState = state;
    mem_resp  = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (reqAny) nextState = WAIT;
      end
      WAIT: begin
        if (!reqAny)              nextState = IDLE;
        else if (waitCnt == 4'd0) nextState = RESP;
      end
      RESP: begin
        mem_resp  = 1'b1;
        nextState = IDLE;
      end
      default: begin
        busy      = 1'b0;
        nextState = IDLE;
      end
    endcase
  end

  // Request capture and wait-state countdown
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      waitCnt <= '0;
      addrQ   <= '0;
      wdataQ  <= '0;
      beQ     <= '0;
      isWrite <= 1'b0;
    end else if (capture) begin
      waitCnt <= 4'(WAIT_STATES);
      addrQ   <= mem_address[AW:1];
      wdataQ  <= mem_wdata;
      beQ     <= mem_byte_enable;
      // Read+write together is resolved as a write.
      isWrite <= mem_write;
    end else if (state == WAIT && waitCnt != 4'd0) begin
      waitCnt <= waitCnt - 4'd1;
    end
  end

  // Read data register: loaded on entry to RESP for reads only
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 mem_rdata <= '0;
    else if (toResp && !isWrite) mem_rdata <= memArray[addrQ];
  end

  // Sticky protocol error on a simultaneous read+write capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                 proto_err <= 1'b0;
    else if (capture && mem_read && mem_write)  proto_err <= 1'b1;
  end

  // Word array: byte-lane write commit at the RESP edge, never reset
  always_ff @(posedge clk) begin
    if (rst_n && state == RESP && isWrite) begin
      if (beQ[0]) memArray[addrQ][7:0]  <= wdataQ[7:0];
      if (beQ[1]) memArray[addrQ][15:8] <= wdataQ[15:8];
    end
  end

endmodule

// File: tb/tb_lc3b_data_mem_responder.sv
// Self-checking bench for lc3b_data_mem_responder with a transaction-level
// reference model (word array + last-read register).
module tb_lc3b_data_mem_responder;

  localparam int DEPTH = 256;
  localparam int WS    = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_read, mem_write;
  logic [15:0] mem_address;
  logic [1:0]  mem_byte_enable;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_resp, busy, proto_err;

  int nChecks = 0;
  int nFails  = 0;

  // reference model
  logic [15:0] model [DEPTH];
  bit          known [DEPTH];
  logic [15:0] lastRead;
  int          writtenIdx [$];

  lc3b_data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_address(mem_address), .mem_byte_enable(mem_byte_enable),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_resp(mem_resp), .busy(busy), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  function automatic int wordIdx(input logic [15:0] a);
    return (int'(a) / 2) % DEPTH;
  endfunction

  function automatic void modelWrite(input logic [15:0] a, input logic [1:0] be, input logic [15:0] d);
    int i = wordIdx(a);
    logic [15:0] w = known[i] ? model[i] : 16'h0000;
    if (be[0]) w = (w & 16'hFF00) | (d & 16'h00FF);
    if (be[1]) w = (w & 16'h00FF) | (d & 16'hFF00);
    if (!known[i]) writtenIdx.push_back(i);
    // a partial first write leaves the other lane undefined
    known[i] = known[i] || (be == 2'b11);
    model[i] = w;
  endfunction

  // Drive one request from the current cycle; returns latency in edges
  // (-1 on timeout), the read data seen with mem_resp and the pulse width.
  task automatic doXfer(input logic rd, input logic wr, input logic [15:0] a,
                        input logic [1:0] be, input logic [15:0] wd,
                        output int lat, output logic [15:0] rdata, output int width);
    mem_read = rd; mem_write = wr; mem_address = a;
    mem_byte_enable = be; mem_wdata = wd;
    lat = -1; rdata = 'x; width = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (mem_resp) begin lat = i; rdata = mem_rdata; break; end
    end
    mem_read = 1'b0; mem_write = 1'b0;
    @(posedge clk); #1;
    if (lat > 0) width = mem_resp ? 2 : 1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    mem_read = 0; mem_write = 0; mem_address = 0; mem_byte_enable = 0; mem_wdata = 0;
    repeat (2) @(posedge clk);
    #1;
    nChecks++;
    if ({mem_resp, busy, proto_err, mem_rdata} !== 19'h0) begin
      nFails++;
      $display("FAIL reset_outputs: got resp=%b busy=%b perr=%b rdata=%h, want all zero",
               mem_resp, busy, proto_err, mem_rdata);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    lastRead = 16'h0000;
  endtask

  task automatic test_basic;
    int lat, w; logic [15:0] rd;
    doXfer(0, 1, 16'h0010, 2'b11, 16'hBEEF, lat, rd, w);
    modelWrite(16'h0010, 2'b11, 16'hBEEF);
    nChecks++;
    if (lat !== 2 + WS) begin nFails++; $display("FAIL write_latency: got %0d want %0d", lat, 2 + WS); end
    nChecks++;
    if (w !== 1) begin nFails++; $display("FAIL write_resp_width: got %0d want 1", w); end
    doXfer(1, 0, 16'h0010, 2'b00, 16'h0000, lat, rd, w);
    lastRead = model[wordIdx(16'h0010)];
    nChecks++;
    if (lat !== 2 + WS) begin nFails++; $display("FAIL read_latency: got %0d want %0d", lat, 2 + WS); end
    nChecks++;
    if (rd !== 16'hBEEF) begin nFails++; $display("FAIL read_beef: got %h want BEEF", rd); end
  endtask

  task automatic test_byte_lanes;
    int lat, w; logic [15:0] rd;
    doXfer(0, 1, 16'h0020, 2'b11, 16'h1234, lat, rd, w); modelWrite(16'h0020, 2'b11, 16'h1234);
    doXfer(0, 1, 16'h0020, 2'b10, 16'hAB00, lat, rd, w); modelWrite(16'h0020, 2'b10, 16'hAB00);
    doXfer(0, 1, 16'h0020, 2'b01, 16'h00CD, lat, rd, w); modelWrite(16'h0020, 2'b01, 16'h00CD);
    nChecks++;
    if (mem_rdata !== lastRead) begin nFails++; $display("FAIL rdata_hold_after_write: got %h want %h", mem_rdata, lastRead); end
    doXfer(0, 1, 16'h0020, 2'b00, 16'hFFFF, lat, rd, w); modelWrite(16'h0020, 2'b00, 16'hFFFF);
    nChecks++;
    if (lat !== 2 + WS) begin nFails++; $display("FAIL be00_completes: got lat %0d want %0d", lat, 2 + WS); end
    doXfer(1, 0, 16'h0020, 2'b00, 16'h0000, lat, rd, w);
    lastRead = model[wordIdx(16'h0020)];
    nChecks++;
    if (rd !== 16'hABCD) begin nFails++; $display("FAIL byte_lanes: got %h want ABCD", rd); end
  endtask

  task automatic test_abort;
    int lat, w; logic [15:0] rd; bit sawResp;
    doXfer(0, 1, 16'h0030, 2'b11, 16'h1111, lat, rd, w); modelWrite(16'h0030, 2'b11, 16'h1111);
    mem_write = 1'b1; mem_address = 16'h0030; mem_byte_enable = 2'b11; mem_wdata = 16'h5555;
    @(posedge clk); #1;
    nChecks++;
    if (busy !== 1'b1) begin nFails++; $display("FAIL abort_captured: busy got %b want 1", busy); end
    mem_write = 1'b0;
    sawResp = 0;
    repeat (10) begin @(posedge clk); #1; if (mem_resp) sawResp = 1; end
    nChecks++;
    if (sawResp !== 1'b0 || busy !== 1'b0) begin
      nFails++; $display("FAIL abort_no_resp: resp seen %b busy %b, want 0 0", sawResp, busy);
    end
    doXfer(1, 0, 16'h0030, 2'b11, 16'h0000, lat, rd, w);
    lastRead = model[wordIdx(16'h0030)];
    nChecks++;
    if (rd !== 16'h1111) begin nFails++; $display("FAIL abort_no_commit: got %h want 1111", rd); end
  endtask

  task automatic test_aliasing;
    int lat, w; logic [15:0] rd;
    doXfer(0, 1, 16'h0002, 2'b11, 16'hCAFE, lat, rd, w); modelWrite(16'h0002, 2'b11, 16'hCAFE);
    doXfer(1, 0, 16'h0202, 2'b00, 16'h0000, lat, rd, w);
    nChecks++;
    if (rd !== 16'hCAFE) begin nFails++; $display("FAIL alias_0202: got %h want CAFE", rd); end
    doXfer(1, 0, 16'h0003, 2'b00, 16'h0000, lat, rd, w);
    lastRead = model[wordIdx(16'h0003)];
    nChecks++;
    if (rd !== 16'hCAFE) begin nFails++; $display("FAIL alias_0003: got %h want CAFE", rd); end
  endtask

  task automatic test_back_to_back;
    int gap, lat, w; logic [15:0] rd;
    mem_write = 1'b1; mem_read = 1'b0; mem_address = 16'h0060;
    mem_byte_enable = 2'b11; mem_wdata = 16'h4242;
    lat = -1;
    for (int i = 1; i <= 40; i++) begin @(posedge clk); #1; if (mem_resp) begin lat = i; break; end end
    modelWrite(16'h0060, 2'b11, 16'h4242);
    // keep requesting straight through: switch to a read of the same word
    mem_write = 1'b0; mem_read = 1'b1;
    gap = -1;
    for (int i = 1; i <= 40; i++) begin @(posedge clk); #1; if (mem_resp) begin gap = i; break; end end
    rd = mem_rdata;
    mem_read = 1'b0;
    @(posedge clk); #1;
    lastRead = model[wordIdx(16'h0060)];
    nChecks++;
    if (lat !== 2 + WS) begin nFails++; $display("FAIL b2b_first_latency: got %0d want %0d", lat, 2 + WS); end
    nChecks++;
    if (gap !== 3 + WS) begin nFails++; $display("FAIL b2b_spacing: got %0d want %0d", gap, 3 + WS); end
    nChecks++;
    if (rd !== 16'h4242) begin nFails++; $display("FAIL b2b_read: got %h want 4242", rd); end
  endtask

  task automatic test_random;
    int lat, w, i; logic [15:0] rd, a, d; logic [1:0] be; bit doRead;
    for (int n = 0; n < 40; n++) begin
      doRead = ($urandom_range(0, 1) == 1) && (writtenIdx.size() > 0);
      if (doRead) begin
        i = writtenIdx[$urandom_range(0, writtenIdx.size() - 1)];
        if (!known[i]) begin
          a = 16'(i * 2);
          doXfer(0, 1, a, 2'b11, model[i], lat, rd, w); modelWrite(a, 2'b11, model[i]);
        end
        a = 16'($urandom_range(0, 65535) / (2 * DEPTH) * (2 * DEPTH) + i * 2 + $urandom_range(0, 1));
        doXfer(1, 0, a, 2'($urandom_range(0, 3)), 16'($urandom), lat, rd, w);
        nChecks++;
        if (lat !== 2 + WS || w !== 1 || rd !== model[i]) begin
          nFails++;
          $display("FAIL rand_read @%h: lat %0d width %0d data %h, want lat %0d width 1 data %h",
                   a, lat, w, rd, 2 + WS, model[i]);
        end
        lastRead = model[i];
      end else begin
        a = 16'($urandom); d = 16'($urandom); be = 2'($urandom_range(0, 3));
        doXfer(0, 1, a, be, d, lat, rd, w);
        modelWrite(a, be, d);
        nChecks++;
        if (lat !== 2 + WS || w !== 1 || mem_rdata !== lastRead) begin
          nFails++;
          $display("FAIL rand_write @%h: lat %0d width %0d rdata %h, want lat %0d width 1 rdata %h",
                   a, lat, w, mem_rdata, 2 + WS, lastRead);
        end
      end
    end
  endtask

  task automatic test_proto_err;
    int lat, w; logic [15:0] rd;
    nChecks++;
    if (proto_err !== 1'b0) begin nFails++; $display("FAIL proto_clear_before: got %b want 0", proto_err); end
    doXfer(1, 1, 16'h0040, 2'b11, 16'h7777, lat, rd, w); modelWrite(16'h0040, 2'b11, 16'h7777);
    nChecks++;
    if (proto_err !== 1'b1) begin nFails++; $display("FAIL proto_set: got %b want 1", proto_err); end
    doXfer(1, 0, 16'h0040, 2'b00, 16'h0000, lat, rd, w);
    lastRead = model[wordIdx(16'h0040)];
    nChecks++;
    if (rd !== 16'h7777 || proto_err !== 1'b1) begin
      nFails++; $display("FAIL proto_as_write: data %h perr %b, want 7777 1", rd, proto_err);
    end
  endtask

  task automatic test_reset_mid;
    int lat, w; logic [15:0] rd;
    doXfer(0, 1, 16'h0050, 2'b11, 16'h2222, lat, rd, w); modelWrite(16'h0050, 2'b11, 16'h2222);
    mem_write = 1'b1; mem_address = 16'h0050; mem_byte_enable = 2'b11; mem_wdata = 16'h9999;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    nChecks++;
    if ({mem_resp, busy, proto_err, mem_rdata} !== 19'h0) begin
      nFails++;
      $display("FAIL reset_mid_outputs: resp=%b busy=%b perr=%b rdata=%h, want all zero",
               mem_resp, busy, proto_err, mem_rdata);
    end
    mem_write = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    doXfer(1, 0, 16'h0050, 2'b00, 16'h0000, lat, rd, w);
    nChecks++;
    if (rd !== 16'h2222) begin nFails++; $display("FAIL reset_mid_no_commit: got %h want 2222", rd); end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin model[i] = 16'h0000; known[i] = 0; end
    test_reset;
    test_basic;
    test_byte_lanes;
    test_abort;
    test_aliasing;
    test_back_to_back;
    test_random;
    test_proto_err;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
